// File: rtl/add_nbit_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per clock with a registered inter-chunk carry.
// Optional signed saturation of the result on overflow when ADD_SAT_EN is defined.
module add_nbit_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             C_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Z,
  output logic             C_OUT,
  output logic             OVF
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'({CHUNK{1'b1}});
`ifdef ADD_SAT_EN
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(1'b1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SAT_POS = ~SAT_NEG;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   z_q, z_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef ADD_SAT_EN
  logic               a_msb_q, a_msb_d;
`endif

  logic [CHUNK-1:0]   a_ch_s;
  logic [CHUNK-1:0]   b_ch_s;
  logic [CHUNK:0]     sum_s;
  logic               msb_cin_s;
  logic               ovf_s;
  logic [31:0]        sh_s;
  logic [WIDTH-1:0]   ins_s;
  logic [WIDTH-1:0]   z_run_s;

  // Chunk adder: operands are shifted down so the active chunk is always the low CHUNK bits.
  always_comb begin
    a_ch_s    = a_q[CHUNK-1:0];
    b_ch_s    = b_q[CHUNK-1:0];
    sum_s     = {1'b0, a_ch_s} + {1'b0, b_ch_s} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the chunk MSB recovered from its sum bit and operand bits.
    msb_cin_s = sum_s[CHUNK-1] ^ a_ch_s[CHUNK-1] ^ b_ch_s[CHUNK-1];
    ovf_s     = msb_cin_s ^ sum_s[CHUNK];
    sh_s      = 32'(cnt_q) * 32'(CHUNK);
    ins_s     = WIDTH'(sum_s[CHUNK-1:0]);
    z_run_s   = (z_q & ~(LOW_MASK << sh_s)) | (ins_s << sh_s);
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ADD_SAT_EN
    a_msb_d = a_msb_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          a_d     = X;
          b_d     = Y ^ {WIDTH{SUB}};
          carry_d = C_IN ^ SUB;
          cnt_d   = {CNT_W{1'b0}};
`ifdef ADD_SAT_EN
          a_msb_d = X[WIDTH-1];
`endif
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = sum_s[CHUNK];
        z_d     = z_run_s;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = sum_s[CHUNK];
          ovf_d   = ovf_s;
`ifdef ADD_SAT_EN
          if (ovf_s) begin
            z_d = a_msb_q ? SAT_NEG : SAT_POS;
          end else begin
            z_d = z_run_s;
          end
`endif
        end else begin
          cnt_d   = cnt_q + CNT_W'(1'b1);
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      z_q     <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADD_SAT_EN
      a_msb_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ADD_SAT_EN
      a_msb_q <= a_msb_d;
`endif
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign Z     = z_q;
  assign C_OUT = cout_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_add_nbit_seq.sv
// Scoreboard bench for add_nbit_seq: a 16/4 instance for the main scenarios and a 1/1 instance
// for the full-adder truth table. Expected results come from an integer-arithmetic model.
module tb_add_nbit_seq;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START, SUB, C_IN;
  logic [15:0] X, Y;
  logic        BUSY, DONE, C_OUT, OVF;
  logic [15:0] Z;

  logic        START1, SUB1, CIN1;
  logic [0:0]  X1, Y1, Z1;
  logic        BUSY1, DONE1, C_OUT1, OVF1;

  typedef struct packed {
    logic [15:0] z;
    logic        c;
    logic        o;
  } exp_t;

  exp_t q[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;
  int   n_done1  = 0;

  always #5 CLK = ~CLK;

  add_nbit_seq #(.WIDTH(16), .CHUNK(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .SUB(SUB), .X(X), .Y(Y), .C_IN(C_IN),
    .BUSY(BUSY), .DONE(DONE), .Z(Z), .C_OUT(C_OUT), .OVF(OVF)
  );

  add_nbit_seq #(.WIDTH(1), .CHUNK(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(START1), .SUB(SUB1), .X(X1), .Y(Y1), .C_IN(CIN1),
    .BUSY(BUSY1), .DONE(DONE1), .Z(Z1), .C_OUT(C_OUT1), .OVF(OVF1)
  );

  function automatic exp_t model16(input bit sub, input logic [15:0] x, input logic [15:0] y, input bit cin);
    exp_t        r;
    logic [16:0] full;
    int          ex;
    if (!sub) begin
      full = {1'b0, x} + {1'b0, y} + 17'(cin);
      r.c  = full[16];
      ex   = int'($signed(x)) + int'($signed(y)) + (cin ? 1 : 0);
    end else begin
      full = {1'b0, x} - {1'b0, y} - 17'(cin);
      r.c  = ~full[16];
      ex   = int'($signed(x)) - int'($signed(y)) - (cin ? 1 : 0);
    end
    r.z = full[15:0];
    r.o = (ex > 32767) || (ex < -32768);
`ifdef ADD_SAT_EN
    if (r.o) r.z = x[15] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  function automatic exp_t model1(input bit x, input bit y, input bit cin);
    exp_t       r;
    logic [1:0] full;
    int         ex;
    full = 2'(x) + 2'(y) + 2'(cin);
    ex   = -(x ? 1 : 0) - (y ? 1 : 0) + (cin ? 1 : 0);
    r.z  = 16'(full[0]);
    r.c  = full[1];
    r.o  = (ex > 0) || (ex < -1);
`ifdef ADD_SAT_EN
    if (r.o) r.z = 16'(x);
`endif
    return r;
  endfunction

  always @(negedge CLK) begin
    if (RST_N && DONE) begin
      n_done++;
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: Z=%h with nothing expected", Z);
      end else begin
        e0 = q.pop_front();
        if ({Z, C_OUT, OVF} !== {e0.z, e0.c, e0.o}) begin
          n_fail++;
          $display("FAIL sb_result: got Z=%h C_OUT=%b OVF=%b, expected Z=%h C_OUT=%b OVF=%b",
                   Z, C_OUT, OVF, e0.z, e0.c, e0.o);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (RST_N && DONE1) begin
      n_done1++;
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL sb1_unexpected_done: Z=%b", Z1);
      end else begin
        e1 = q1.pop_front();
        if ({Z1, C_OUT1, OVF1} !== {e1.z[0], e1.c, e1.o}) begin
          n_fail++;
          $display("FAIL sb1_result: got Z=%b C_OUT=%b OVF=%b, expected Z=%b C_OUT=%b OVF=%b",
                   Z1, C_OUT1, OVF1, e1.z[0], e1.c, e1.o);
        end
      end
    end
  end

  task automatic issue(input bit sub, input logic [15:0] x, input logic [15:0] y, input bit cin);
    SUB = sub; X = x; Y = y; C_IN = cin; START = 1'b1;
    q.push_back(model16(sub, x, y, cin));
    @(posedge CLK); #1;
    START = 1'b0;
    SUB = 1'($urandom); X = 16'($urandom); Y = 16'($urandom); C_IN = 1'($urandom);
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (n_done < target && k < 30) begin
      @(posedge CLK); #1;
      k++;
    end
    n_checks++;
    if (n_done < target) begin
      n_fail++;
      $display("FAIL %s_timeout: done count %0d, required %0d", name, n_done, target);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; START = 1'b0; SUB = 1'b0; X = 16'h0; Y = 16'h0; C_IN = 1'b0;
    START1 = 1'b0; SUB1 = 1'b0; X1 = 1'b0; Y1 = 1'b0; CIN1 = 1'b0;
    #12;
    n_checks++;
    if ({BUSY, DONE, Z, C_OUT, OVF} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_state: BUSY=%b DONE=%b Z=%h C_OUT=%b OVF=%b, required all 0", BUSY, DONE, Z, C_OUT, OVF);
    end
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_add_latency();
    issue(1'b0, 16'h1234, 16'h1111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) begin
        n_fail++;
        $display("FAIL add_busy_cycle%0d: BUSY=%b DONE=%b, required BUSY=1 DONE=0", i, BUSY, DONE);
      end
      @(posedge CLK); #1;
    end
    n_checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || Z !== 16'h2345 || C_OUT !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done: DONE=%b BUSY=%b Z=%h C_OUT=%b OVF=%b, required 1 0 2345 0 0", DONE, BUSY, Z, C_OUT, OVF);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL add_done_pulse: DONE=%b, required 0", DONE);
    end
  endtask

  task automatic test_carry_ovf();
    logic [15:0] zexp;
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    wait_done(n_done + 1, "carry");
    n_checks++;
    if (Z !== 16'h0000 || C_OUT !== 1'b1 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_wrap: Z=%h C_OUT=%b OVF=%b, required 0000 1 0", Z, C_OUT, OVF);
    end
    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    wait_done(n_done + 1, "ovf");
`ifdef ADD_SAT_EN
    zexp = 16'h7FFF;
`else
    zexp = 16'h8000;
`endif
    n_checks++;
    if (Z !== zexp || OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL signed_ovf: Z=%h OVF=%b, required %h 1", Z, OVF, zexp);
    end
  endtask

  task automatic test_sub();
    logic [15:0] zexp;
    issue(1'b1, 16'h0005, 16'h0007, 1'b0);
    wait_done(n_done + 1, "sub");
    n_checks++;
    if (Z !== 16'hFFFE || C_OUT !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: Z=%h C_OUT=%b OVF=%b, required fffe 0 0", Z, C_OUT, OVF);
    end
    issue(1'b1, 16'h8000, 16'h0001, 1'b0);
    wait_done(n_done + 1, "sub_ovf");
`ifdef ADD_SAT_EN
    zexp = 16'h8000;
`else
    zexp = 16'h7FFF;
`endif
    n_checks++;
    if (Z !== zexp || C_OUT !== 1'b1 || OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_ovf: Z=%h C_OUT=%b OVF=%b, required %h 1 1", Z, C_OUT, OVF, zexp);
    end
  endtask

  task automatic test_back_to_back();
    START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      SUB = 1'(i); X = 16'h1000 * 16'(i + 1) + 16'h0123; Y = 16'h0F0F; C_IN = 1'(i >> 1);
      q.push_back(model16(SUB, X, Y, C_IN));
      @(posedge CLK); #1;
      repeat (4) begin @(posedge CLK); #1; end
      n_checks++;
      if (DONE !== 1'b1 || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_done%0d: DONE=%b BUSY=%b, required 1 0", i, DONE, BUSY);
      end
      if (i == 2) START = 1'b0;
    end
    @(posedge CLK); #1;
    n_checks++;
    if (BUSY !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: BUSY=%b pending=%0d, required 0 0", BUSY, q.size());
    end
  endtask

  task automatic test_ignore_busy();
    int target;
    issue(1'b0, 16'h0F0F, 16'h0101, 1'b0);
    target = n_done + 1;
    @(posedge CLK); #1;
    START = 1'b1; SUB = 1'b1; X = 16'hFFFF; Y = 16'hFFFF; C_IN = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    wait_done(target, "ignore");
    repeat (8) begin @(posedge CLK); #1; end
    n_checks++;
    if (n_done != target || Z !== 16'h1010) begin
      n_fail++;
      $display("FAIL ignore_busy: done count %0d Z=%h, required %0d 1010", n_done, Z, target);
    end
  endtask

  task automatic test_reset_midop();
    int base;
    issue(1'b1, 16'h8000, 16'h0001, 1'b0);
    wait_done(n_done + 1, "pre_rst");
    issue(1'b0, 16'h00FF, 16'h0011, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    q.delete();
    n_checks++;
    if ({BUSY, DONE, Z, C_OUT, OVF} !== 20'h0) begin
      n_fail++;
      $display("FAIL rst_midop: BUSY=%b DONE=%b Z=%h C_OUT=%b OVF=%b, required all 0", BUSY, DONE, Z, C_OUT, OVF);
    end
    base = n_done;
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    repeat (8) begin @(posedge CLK); #1; end
    n_checks++;
    if (n_done != base) begin
      n_fail++;
      $display("FAIL rst_no_done: done count %0d, required %0d", n_done, base);
    end
    issue(1'b0, 16'h4321, 16'h1234, 1'b1);
    wait_done(n_done + 1, "post_rst");
    n_checks++;
    if (Z !== 16'h5556 || C_OUT !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_add: Z=%h C_OUT=%b OVF=%b, required 5556 0 0", Z, C_OUT, OVF);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      issue(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      wait_done(n_done + 1, "random");
    end
  endtask

  task automatic test_width1();
    for (int i = 0; i < 8; i++) begin
      X1 = 1'(i >> 2); Y1 = 1'(i >> 1); CIN1 = 1'(i); SUB1 = 1'b0; START1 = 1'b1;
      q1.push_back(model1(X1[0], Y1[0], CIN1));
      @(posedge CLK); #1;
      START1 = 1'b0;
      n_checks++;
      if (BUSY1 !== 1'b1 || DONE1 !== 1'b0) begin
        n_fail++;
        $display("FAIL w1_busy%0d: BUSY=%b DONE=%b, required 1 0", i, BUSY1, DONE1);
      end
      @(posedge CLK); #1;
      n_checks++;
      if (DONE1 !== 1'b1) begin
        n_fail++;
        $display("FAIL w1_done%0d: DONE=%b, required 1", i, DONE1);
      end
      @(posedge CLK); #1;
    end
    n_checks++;
    if (n_done1 != 8) begin
      n_fail++;
      $display("FAIL w1_count: done count %0d, required 8", n_done1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_latency();
    test_carry_ovf();
    test_sub();
    test_back_to_back();
    test_ignore_busy();
    test_reset_midop();
    test_random();
    test_width1();
    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
